// File: rtl/saes_iter_core.sv
// saes_iter_core: iterative valid/ready 16-bit S-AES encrypt/decrypt core with bypass.
// Define SAES_KEY_CACHE_EN to keep the expanded key schedule and skip KEYEXP on a key match.
module saes_iter_core #(
    parameter int ROUNDS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_key,
    input  logic [15:0] in_text,
    input  logic        in_op,
    input  logic        in_bypass,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_text,
    output logic        busy
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS);
    localparam logic [63:0] SBOX  = 64'h94ABD1856203CEF7;
    localparam logic [63:0] ISBOX = 64'hA59B178F6023C4DE;

    typedef enum logic [2:0] {IDLE, KEYEXP, WHITEN, ROUND, DONE} state_t;

    state_t        r_state, w_next;
    logic [15:0]   r_st;
    logic [15:0]   r_keys [0:ROUNDS];
    logic          r_op;
    logic [CW-1:0] r_cnt;
    logic          w_hs, w_hit;
    logic [15:0]   w_k, w_t, w_u, w_enc, w_dec;

    function automatic logic [3:0] sb(input logic [63:0] t, input logic [3:0] n);
        return t[(15 - n) * 4 +: 4];
    endfunction

    function automatic logic [15:0] sub16(input logic [63:0] t, input logic [15:0] s);
        return {sb(t, s[15:12]), sb(t, s[11:8]), sb(t, s[7:4]), sb(t, s[3:0])};
    endfunction

    function automatic logic [15:0] sr(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [3:0] xt(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            p = p ^ (b[i] ? x : 4'h0);
            x = xt(x);
        end
        return p;
    endfunction

    // Column mix with symmetric matrix [d o; o d]: MC is (1,4), InvMC is (9,2)
    function automatic logic [15:0] mix(input logic [15:0] s, input logic [3:0] d, input logic [3:0] o);
        return {gmul(d, s[15:12]) ^ gmul(o, s[11:8]), gmul(o, s[15:12]) ^ gmul(d, s[11:8]),
                gmul(d, s[7:4]) ^ gmul(o, s[3:0]), gmul(o, s[7:4]) ^ gmul(d, s[3:0])};
    endfunction

    function automatic logic [15:0] expand(input logic [15:0] k, input logic [CW-1:0] r);
        logic [3:0] rc;
        logic [7:0] w2;
        rc = 4'h4;
        for (int i = 0; i < ROUNDS; i++)
            if (i < int'(r)) rc = xt(rc);
        w2 = k[15:8] ^ {rc, 4'h0} ^ {sb(SBOX, k[3:0]), sb(SBOX, k[7:4])};
        return {w2, w2 ^ k[7:0]};
    endfunction

    assign in_ready  = rst_n && r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign out_text  = r_st;
    assign w_hs      = in_valid && in_ready;
    assign w_k       = r_keys[r_cnt];
    assign w_t       = sr(sub16(SBOX, r_st));
    assign w_enc     = w_k ^ (r_cnt == LAST ? w_t : mix(w_t, 4'h1, 4'h4));
    assign w_u       = sub16(ISBOX, sr(r_st)) ^ w_k;
    assign w_dec     = r_cnt == '0 ? w_u : mix(w_u, 4'h9, 4'h2);

`ifdef SAES_KEY_CACHE_EN
    logic r_kv;
    always_ff @(posedge clk) begin
        if (!rst_n) r_kv <= 1'b0;
        else if (r_state == KEYEXP && r_cnt == LAST) r_kv <= 1'b1;
    end
    assign w_hit = r_kv && in_key == r_keys[0];
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = in_bypass ? DONE : (w_hit ? WHITEN : KEYEXP);
            KEYEXP:  if (r_cnt == LAST) w_next = WHITEN;
            WHITEN:  w_next = ROUND;
            ROUND:   if (r_op ? r_cnt == LAST : r_cnt == '0) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bypass leaves K[0] alone so a cached schedule stays coherent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st  <= '0;
            r_op  <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_hs) begin
                    r_st  <= in_text;
                    r_op  <= in_op;
                    r_cnt <= CW'(1);
                    if (!in_bypass) r_keys[0] <= in_key;
                end
                KEYEXP: begin
                    r_keys[r_cnt] <= expand(r_keys[r_cnt - CW'(1)], r_cnt);
                    r_cnt         <= r_cnt + CW'(1);
                end
                WHITEN: begin
                    r_st  <= r_st ^ (r_op ? r_keys[0] : r_keys[LAST]);
                    r_cnt <= r_op ? CW'(1) : LAST - CW'(1);
                end
                ROUND: begin
                    r_st  <= r_op ? w_enc : w_dec;
                    r_cnt <= r_op ? r_cnt + CW'(1) : r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_saes_iter_core.sv
// tb_saes_iter_core: vector table, backpressure/reset sequences and randomized
// round-trip checks for saes_iter_core at ROUNDS=2 and ROUNDS=4.
module tb_saes_iter_core;
`ifdef SAES_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int SB[16] = '{9, 4, 10, 11, 13, 1, 8, 5, 6, 2, 0, 3, 12, 14, 15, 7};

    typedef struct {
        bit          op;
        bit          byp;
        logic [15:0] key;
        logic [15:0] txt;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv[2], iop[2], ib[2], orr[2];
    logic [15:0] ik[2], it[2];
    logic        ir0, ir1, ov0, ov1, bz0, bz1;
    logic [15:0] ot0, ot1;
    int          n_chk = 0, n_err = 0;
    bit          cv[2];
    logic [15:0] ck[2];
    vec_t        tbl[8];

    always #5 clk = ~clk;

    saes_iter_core #(.ROUNDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .in_key(ik[0]),
        .in_text(it[0]), .in_op(iop[0]), .in_bypass(ib[0]), .out_valid(ov0),
        .out_ready(orr[0]), .out_text(ot0), .busy(bz0));

    saes_iter_core #(.ROUNDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .in_key(ik[1]),
        .in_text(it[1]), .in_op(iop[1]), .in_bypass(ib[1]), .out_valid(ov1),
        .out_ready(orr[1]), .out_text(ot1), .busy(bz1));

    function automatic int gm(int a, int b);
        int p = 0;
        for (int i = 0; i < 4; i++) begin
            if ((b & (1 << i)) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 16) != 0) a = a ^ 19;
        end
        return p;
    endfunction

    function automatic logic [15:0] next_key(input logic [15:0] k, input int r);
        int rc, w0, w1, w2;
        rc = 4;
        for (int j = 0; j < r; j++) rc = gm(rc, 2);
        w0 = int'(k[15:8]);
        w1 = int'(k[7:0]);
        w2 = w0 ^ (rc << 4) ^ (SB[w1 & 15] << 4) ^ SB[w1 >> 4];
        return 16'((w2 << 8) | (w2 ^ w1));
    endfunction

    function automatic logic [15:0] m_enc(input logic [15:0] key, input logic [15:0] pt, input int rounds);
        logic [15:0] k;
        int s[4];
        int t;
        k = key;
        for (int i = 0; i < 4; i++) s[i] = (int'(pt ^ k) >> (12 - 4 * i)) & 15;
        for (int r = 1; r <= rounds; r++) begin
            k = next_key(k, r);
            for (int i = 0; i < 4; i++) s[i] = SB[s[i]];
            t = s[1]; s[1] = s[3]; s[3] = t;
            if (r < rounds)
                for (int c = 0; c < 4; c += 2) begin
                    t = s[c];
                    s[c] = t ^ gm(4, s[c+1]);
                    s[c+1] = gm(4, t) ^ s[c+1];
                end
            for (int i = 0; i < 4; i++) s[i] = s[i] ^ ((int'(k) >> (12 - 4 * i)) & 15);
        end
        return 16'((s[0] << 12) | (s[1] << 8) | (s[2] << 4) | s[3]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_lat(input int d, input bit byp, input logic [15:0] key, output int lat);
        int r;
        r = d == 1 ? 4 : 2;
        lat = byp ? 1 : (CACHE && cv[d] && ck[d] == key) ? r + 2 : 2 * r + 2;
        if (!byp) begin
            cv[d] = 1'b1;
            ck[d] = key;
        end
    endtask

    task automatic issue(input int d, input bit op, input bit byp, input logic [15:0] key, input logic [15:0] txt);
        int w = 0;
        @(negedge clk);
        while (!(d == 1 ? ir1 : ir0) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 32'(d == 1 ? ir1 : ir0), 1);
        iv[d] = 1'b1; iop[d] = op; ib[d] = byp; ik[d] = key; it[d] = txt;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        iop[d] = 1'($urandom);
        ib[d] = 1'($urandom);
        ik[d] = 16'($urandom);
        it[d] = 16'($urandom);
    endtask

    task automatic await_out(input int d, output logic [15:0] res, output int lat);
        lat = 1;
        @(negedge clk);
        while (!(d == 1 ? ov1 : ov0) && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("out_valid_wait", 32'(d == 1 ? ov1 : ov0), 1);
        res = d == 1 ? ot1 : ot0;
    endtask

    task automatic release_out(input int d);
        orr[d] = 1'b1;
        @(posedge clk);
        #1;
        orr[d] = 1'b0;
    endtask

    task automatic xact(input int d, input bit op, input bit byp, input logic [15:0] key,
                        input logic [15:0] txt, output logic [15:0] res, output int lat);
        issue(d, op, byp, key, txt);
        await_out(d, res, lat);
        release_out(d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res, c, p, key;
        int lat, el;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; iop[d] = 1'b0; ib[d] = 1'b0; orr[d] = 1'b0;
            ik[d] = '0; it[d] = '0; cv[d] = 1'b0; ck[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ir0), 0);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_out_text", 32'(ot0), 0);
        chk("rst_busy", 32'(bz0), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(ir0), 1);
        chk("post_rst_in_ready4", 32'(ir1), 1);

        tbl[0] = '{1'b1, 1'b0, 16'h4AF5, 16'hD728, 16'h24EC};
        tbl[1] = '{1'b0, 1'b0, 16'h4AF5, 16'h24EC, 16'hD728};
        tbl[2] = '{1'b0, 1'b1, 16'($urandom), 16'h1234, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 16'h4AF5, 16'hD728, 16'h24EC};
        tbl[4] = '{1'b1, 1'b0, 16'hA1B2, 16'h3C4D, m_enc(16'hA1B2, 16'h3C4D, 2)};
        tbl[5] = '{1'b0, 1'b0, 16'hA1B2, m_enc(16'hA1B2, 16'h3C4D, 2), 16'h3C4D};
        tbl[6] = '{1'b1, 1'b1, 16'hA1B2, 16'hFFFF, 16'hFFFF};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, m_enc(16'h0000, 16'h0000, 2)};
        for (int i = 0; i < 8; i++) begin
            model_lat(0, tbl[i].byp, tbl[i].key, el);
            xact(0, tbl[i].op, tbl[i].byp, tbl[i].key, tbl[i].txt, res, lat);
            chk($sformatf("vec%0d_text", i), 32'(res), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_latency", i), lat, el);
        end

        // Backpressure: hold the result for ten cycles
        issue(0, 1'b1, 1'b0, 16'h4AF5, 16'hD728);
        model_lat(0, 1'b0, 16'h4AF5, el);
        await_out(0, res, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ov0), 1);
            chk("hold_text", 32'(ot0), 32'h24EC);
            chk("hold_in_ready", 32'(ir0), 0);
        end
        release_out(0);
        @(negedge clk);
        chk("release_valid", 32'(ov0), 0);
        chk("release_in_ready", 32'(ir0), 1);
        chk("release_busy", 32'(bz0), 0);

        // Reset while in ROUND discards the block and the key cache
        issue(0, 1'b1, 1'b0, 16'h4AF5, 16'hD728);
        repeat (CACHE ? 1 : 3) @(posedge clk);
        @(negedge clk);
        chk("midround_busy", 32'(bz0), 1);
        chk("midround_valid", 32'(ov0), 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(ov0), 0);
        chk("midrst_text", 32'(ot0), 0);
        chk("midrst_in_ready", 32'(ir0), 0);
        chk("midrst_busy", 32'(bz0), 0);
        rst_n = 1'b1;
        cv[0] = 1'b0;
        cv[1] = 1'b0;
        #1;
        chk("midrst_in_ready_after", 32'(ir0), 1);
        model_lat(0, 1'b0, 16'h4AF5, el);
        xact(0, 1'b1, 1'b0, 16'h4AF5, 16'hD728, res, lat);
        chk("after_rst_text", 32'(res), 32'h24EC);
        chk("after_rst_latency", lat, el);

        // ROUNDS=4 random round trips
        for (int i = 0; i < 64; i++) begin
            key = 16'($urandom);
            p = 16'($urandom);
            model_lat(1, 1'b0, key, el);
            xact(1, 1'b1, 1'b0, key, p, c, lat);
            chk($sformatf("rnd%0d_enc", i), 32'(c), 32'(m_enc(key, p, 4)));
            chk($sformatf("rnd%0d_enc_lat", i), lat, el);
            model_lat(1, 1'b0, key, el);
            xact(1, 1'b0, 1'b0, key, c, res, lat);
            chk($sformatf("rnd%0d_dec", i), 32'(res), 32'(p));
            chk($sformatf("rnd%0d_dec_lat", i), lat, el);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
